// File: rtl/dma_desc_pkg.sv
// Shared helpers for the DMA descriptor round-robin arbiter.
// Port-index width and {port, tag} packing used by grant and status paths.
package dma_desc_pkg;

    function automatic int port_idx_w(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    function automatic logic [63:0] tag_pack(
        input logic [63:0] idx,
        input logic [63:0] tag,
        input int          s_w
    );
        return (idx << s_w) | tag;
    endfunction

    function automatic int tag_port(
        input logic [63:0] tag,
        input int          s_w
    );
        return int'(tag >> s_w);
    endfunction

endpackage

// File: rtl/dma_desc_rr_arb_prio.sv
// Cyclic first-set search starting at ptr: one-hot grant, index, any.
// Also used with ptr=0 as a plain one-hot decoder for the status path.
module rr_priority_encoder #(
    parameter int PORTS    = 4,
    parameter int CL_PORTS = 2
) (
    input  logic [PORTS-1:0]    req,
    input  logic [CL_PORTS-1:0] ptr,
    output logic [PORTS-1:0]    gnt,
    output logic [CL_PORTS-1:0] idx,
    output logic                any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            j = (int'(ptr) + k) % PORTS;
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = CL_PORTS'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_desc_rr_arb.sv
// Round-robin sharing of one DMA descriptor channel between PORTS requesters,
// with per-port inflight limit and status routing by tag-embedded port index.
import dma_desc_pkg::*;

module dma_desc_rr_arb #(
    parameter int PORTS           = 4,
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int RAM_SEL_WIDTH   = 2,
    parameter int RAM_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 16,
    parameter int S_TAG_WIDTH     = 6,
    parameter int CL_PORTS        = port_idx_w(PORTS),
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + CL_PORTS,
    parameter int MAX_INFLIGHT    = 16,
    parameter int CNT_WIDTH       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [PORTS*PCIE_ADDR_WIDTH-1:0]    s_axis_desc_pcie_addr,
    input  logic [PORTS*RAM_SEL_WIDTH-1:0]      s_axis_desc_ram_sel,
    input  logic [PORTS*RAM_ADDR_WIDTH-1:0]     s_axis_desc_ram_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]          s_axis_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]        s_axis_desc_tag,
    input  logic [PORTS-1:0]                    s_axis_desc_valid,
    output logic [PORTS-1:0]                    s_axis_desc_ready,
    output logic [PCIE_ADDR_WIDTH-1:0]          m_axis_desc_pcie_addr,
    output logic [RAM_SEL_WIDTH-1:0]            m_axis_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0]           m_axis_desc_ram_addr,
    output logic [LEN_WIDTH-1:0]                m_axis_desc_len,
    output logic [M_TAG_WIDTH-1:0]              m_axis_desc_tag,
    output logic                                m_axis_desc_valid,
    input  logic                                m_axis_desc_ready,
    input  logic [M_TAG_WIDTH-1:0]              s_axis_desc_status_tag,
    input  logic                                s_axis_desc_status_valid,
    output logic [S_TAG_WIDTH-1:0]              m_axis_desc_status_tag,
    output logic [PORTS-1:0]                    m_axis_desc_status_valid,
    input  logic                                enable,
    output logic [PORTS*CNT_WIDTH-1:0]          inflight_count,
    output logic                                status_error
);

    typedef struct packed {
        logic [PCIE_ADDR_WIDTH-1:0] pcie_addr;
        logic [RAM_SEL_WIDTH-1:0]   ram_sel;
        logic [RAM_ADDR_WIDTH-1:0]  ram_addr;
        logic [LEN_WIDTH-1:0]       len;
        logic [M_TAG_WIDTH-1:0]     tag;
    } desc_t;

    desc_t                 in_desc [PORTS];
    desc_t                 desc_q, desc_d;
    logic                  valid_q, valid_d;
    logic [CL_PORTS-1:0]   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q [PORTS];
    logic [CNT_WIDTH-1:0]  cnt_d [PORTS];
    logic [PORTS-1:0]      st_valid_q, st_valid_d;
    logic [S_TAG_WIDTH-1:0] st_tag_q, st_tag_d;
    logic                  st_err_q, st_err_d;

    logic [PORTS-1:0]      elig, gnt, st_req, st_hot;
    logic [CL_PORTS-1:0]   gidx, st_idx;
    logic                  gany, st_hit, free, fire;
    int                    st_port;

    assign st_port = tag_port(64'(s_axis_desc_status_tag), S_TAG_WIDTH);

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        assign in_desc[i].pcie_addr =
            s_axis_desc_pcie_addr[i*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
        assign in_desc[i].ram_sel =
            s_axis_desc_ram_sel[i*RAM_SEL_WIDTH +: RAM_SEL_WIDTH];
        assign in_desc[i].ram_addr =
            s_axis_desc_ram_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
        assign in_desc[i].len =
            s_axis_desc_len[i*LEN_WIDTH +: LEN_WIDTH];
        assign in_desc[i].tag = M_TAG_WIDTH'(tag_pack(64'(i),
            64'(s_axis_desc_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH]),
            S_TAG_WIDTH));
        assign elig[i] = s_axis_desc_valid[i] & enable & ~rst &
            (cnt_q[i] < CNT_WIDTH'(MAX_INFLIGHT));
        assign st_req[i] = s_axis_desc_status_valid & (st_port == i);
        assign inflight_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end

    rr_priority_encoder #(.PORTS(PORTS), .CL_PORTS(CL_PORTS)) u_grant (
        .req (elig),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    // An out-of-range port index simply produces no hit and is dropped.
    rr_priority_encoder #(.PORTS(PORTS), .CL_PORTS(CL_PORTS)) u_st_dec (
        .req (st_req),
        .ptr ('0),
        .gnt (st_hot),
        .idx (st_idx),
        .any (st_hit)
    );

    assign free = ~valid_q | m_axis_desc_ready;
    assign fire = free & gany;
    assign s_axis_desc_ready = free ? gnt : '0;

    always_comb begin
        desc_d  = desc_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (free) begin
            valid_d = gany;
        end
        if (fire) begin
            desc_d = in_desc[gidx];
            ptr_d  = (gidx == CL_PORTS'(PORTS - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_comb begin
        logic inc, dec;
        inc        = 1'b0;
        dec        = 1'b0;
        st_valid_d = st_hot;
        st_tag_d   = st_tag_q;
        st_err_d   = 1'b0;
        if (s_axis_desc_status_valid) begin
            st_tag_d = s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
            st_err_d = ~st_hit | (cnt_q[st_idx] == '0);
        end
        for (int i = 0; i < PORTS; i++) begin
            inc      = fire & gnt[i];
            dec      = st_hot[i] & (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ptr_q      <= '0;
            st_valid_q <= '0;
            st_err_q   <= 1'b0;
            for (int i = 0; i < PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
            st_valid_q <= st_valid_d;
            st_err_q   <= st_err_d;
            for (int i = 0; i < PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        desc_q   <= desc_d;
        st_tag_q <= st_tag_d;
    end

    assign m_axis_desc_pcie_addr    = desc_q.pcie_addr;
    assign m_axis_desc_ram_sel      = desc_q.ram_sel;
    assign m_axis_desc_ram_addr     = desc_q.ram_addr;
    assign m_axis_desc_len          = desc_q.len;
    assign m_axis_desc_tag          = desc_q.tag;
    assign m_axis_desc_valid        = valid_q;
    assign m_axis_desc_status_tag   = st_tag_q;
    assign m_axis_desc_status_valid = st_valid_q;
    assign status_error             = st_err_q;

endmodule

// File: tb/tb_dma_desc_rr_arb.sv
// Bench for dma_desc_rr_arb: cycle model plus directed literal checks
// and a randomized traffic phase.
module tb_dma_desc_rr_arb;

    localparam int P   = 4;
    localparam int AW  = 64;
    localparam int SW  = 2;
    localparam int RW  = 16;
    localparam int LW  = 16;
    localparam int TW  = 6;
    localparam int MT  = 8;
    localparam int MAX = 16;
    localparam int CW  = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [P*AW-1:0] s_addr = '0;
    logic [P*SW-1:0] s_sel = '0;
    logic [P*RW-1:0] s_raddr = '0;
    logic [P*LW-1:0] s_len = '0;
    logic [P*TW-1:0] s_tag = '0;
    logic [P-1:0]    s_valid = '0;
    logic [P-1:0]    s_ready;
    logic [AW-1:0]   m_addr;
    logic [SW-1:0]   m_sel;
    logic [RW-1:0]   m_raddr;
    logic [LW-1:0]   m_len;
    logic [MT-1:0]   m_tag;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [MT-1:0]   st_in_tag = '0;
    logic            st_in_valid = 1'b0;
    logic [TW-1:0]   st_tag;
    logic [P-1:0]    st_valid;
    logic            enable = 1'b1;
    logic [P*CW-1:0] counts;
    logic            st_err;

    int n_chk = 0;
    int n_fail = 0;

    dma_desc_rr_arb dut (
        .clk                      (clk),
        .rst                      (rst),
        .s_axis_desc_pcie_addr    (s_addr),
        .s_axis_desc_ram_sel      (s_sel),
        .s_axis_desc_ram_addr     (s_raddr),
        .s_axis_desc_len          (s_len),
        .s_axis_desc_tag          (s_tag),
        .s_axis_desc_valid        (s_valid),
        .s_axis_desc_ready        (s_ready),
        .m_axis_desc_pcie_addr    (m_addr),
        .m_axis_desc_ram_sel      (m_sel),
        .m_axis_desc_ram_addr     (m_raddr),
        .m_axis_desc_len          (m_len),
        .m_axis_desc_tag          (m_tag),
        .m_axis_desc_valid        (m_valid),
        .m_axis_desc_ready        (m_ready),
        .s_axis_desc_status_tag   (st_in_tag),
        .s_axis_desc_status_valid (st_in_valid),
        .m_axis_desc_status_tag   (st_tag),
        .m_axis_desc_status_valid (st_valid),
        .enable                   (enable),
        .inflight_count           (counts),
        .status_error             (st_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int i);
        return int'(counts[i*CW +: CW]);
    endfunction

    // Behavioural model: outputs predicted from the arbitration rules.
    bit            m_ok = 0;
    int            m_cnt [P];
    int            m_ptr;
    logic          e_mvalid;
    logic [AW-1:0] e_addr;
    logic [SW-1:0] e_sel;
    logic [RW-1:0] e_raddr;
    logic [LW-1:0] e_len;
    logic [MT-1:0] e_tag;
    logic [P-1:0]  e_sv;
    logic [TW-1:0] e_stag;
    logic          e_err;

    initial begin
        forever begin
            int  g;
            bit  fr;
            int  old [P];
            int  p;
            logic [P-1:0] exp_rdy;
            @(negedge clk);
            if (m_ok) begin
                chk("m_valid", m_valid, e_mvalid);
                if (e_mvalid) begin
                    chk("m_addr", m_addr, e_addr);
                    chk("m_sel", m_sel, e_sel);
                    chk("m_raddr", m_raddr, e_raddr);
                    chk("m_len", m_len, e_len);
                    chk("m_tag", m_tag, e_tag);
                end
                chk("st_valid", st_valid, e_sv);
                if (e_sv != 0) chk("st_tag", st_tag, e_stag);
                chk("st_err", st_err, e_err);
                for (int i = 0; i < P; i++) chk("count", cnt_of(i), m_cnt[i]);
            end
            fr = !e_mvalid || m_ready;
            g = -1;
            if (m_ok && !rst && fr && enable) begin
                for (int k = 0; k < P; k++) begin
                    int j;
                    j = (m_ptr + k) % P;
                    if (g < 0 && s_valid[j] && m_cnt[j] < MAX) g = j;
                end
            end
            exp_rdy = (g >= 0) ? P'(1 << g) : '0;
            if (m_ok) chk("s_ready", s_ready, exp_rdy);
            @(posedge clk);
            if (rst) begin
                m_ok = 1;
                m_ptr = 0;
                e_mvalid = 0;
                e_sv = '0;
                e_err = 0;
                for (int i = 0; i < P; i++) m_cnt[i] = 0;
            end else if (m_ok) begin
                for (int i = 0; i < P; i++) old[i] = m_cnt[i];
                if (fr) e_mvalid = (g >= 0);
                if (g >= 0) begin
                    e_addr  = s_addr[g*AW +: AW];
                    e_sel   = s_sel[g*SW +: SW];
                    e_raddr = s_raddr[g*RW +: RW];
                    e_len   = s_len[g*LW +: LW];
                    e_tag   = MT'(g * 64 + int'(s_tag[g*TW +: TW]));
                    m_ptr   = (g + 1) % P;
                    m_cnt[g]++;
                end
                e_sv = '0;
                e_err = 0;
                if (st_in_valid) begin
                    p = int'(st_in_tag) / 64;
                    if (p >= P) begin
                        e_err = 1;
                    end else begin
                        e_sv = P'(1 << p);
                        e_stag = TW'(int'(st_in_tag) % 64);
                        if (old[p] == 0) e_err = 1;
                        else m_cnt[p]--;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic [TW-1:0] t);
        s_addr[i*AW +: AW]  = {$urandom, $urandom};
        s_sel[i*SW +: SW]   = SW'($urandom);
        s_raddr[i*RW +: RW] = RW'($urandom);
        s_len[i*LW +: LW]   = LW'($urandom);
        s_tag[i*TW +: TW]   = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [MT-1:0] held_tag;
        logic [AW-1:0] held_addr;
        do_reset();
        step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_counts", counts, 0);
        chk("rst_st_err", st_err, 0);

        set_port(2, 6'h15);
        s_valid = 4'b0100;
        #1 chk("single_ready", s_ready, 4'b0100);
        step();
        s_valid = '0;
        chk("single_valid", m_valid, 1);
        chk("single_tag", m_tag, 8'h95);
        chk("single_cnt", cnt_of(2), 1);

        do_reset();
        for (int i = 0; i < P; i++) set_port(i, TW'(i + 8));
        s_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            step();
            chk("rr_order", m_tag[7:6], n % 4);
        end

        m_ready = 1'b0;
        step();
        held_tag = m_tag;
        held_addr = m_addr;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("hold_tag", m_tag, held_tag);
            chk("hold_addr", m_addr, held_addr);
            chk("hold_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        s_valid = '0;
        step();

        do_reset();
        set_port(1, 6'h2A);
        s_valid = 4'b0010;
        for (int n = 0; n < 16; n++) step();
        chk("lim_cnt", cnt_of(1), 16);
        chk("lim_ready", s_ready, 0);
        step();
        chk("lim_idle", m_valid, 0);
        set_port(0, 6'h01);
        s_valid = 4'b0011;
        #1 chk("lim_skip", s_ready, 4'b0001);
        step();
        chk("lim_p0_tag", m_tag, 8'h01);
        s_valid = 4'b0010;
        st_in_tag = 8'h4A;
        st_in_valid = 1'b1;
        step();
        st_in_valid = 1'b0;
        chk("st_hot", st_valid, 4'b0010);
        chk("st_tag", st_tag, 6'h0A);
        chk("st_cnt", cnt_of(1), 15);
        #1 chk("lim_regrant", s_ready, 4'b0010);
        step();
        chk("lim_regrant_tag", m_tag, 8'h6A);
        s_valid = '0;
        step();

        do_reset();
        set_port(3, 6'h07);
        s_valid = 4'b1000;
        for (int n = 0; n < 5; n++) step();
        chk("p3_cnt5", cnt_of(3), 5);
        st_in_tag = 8'hC7;
        st_in_valid = 1'b1;
        step();
        s_valid = '0;
        chk("same_cyc_cnt", cnt_of(3), 5);
        chk("same_cyc_st", st_valid, 4'b1000);
        st_in_tag = 8'h03;
        step();
        st_in_valid = 1'b0;
        chk("zero_err", st_err, 1);
        chk("zero_cnt", cnt_of(0), 0);
        chk("zero_fwd", st_valid, 4'b0001);
        step();
        chk("zero_err_pulse", st_err, 0);

        s_valid = 4'b1000;
        m_ready = 1'b0;
        step();
        s_valid = '0;
        chk("mid_valid", m_valid, 1);
        rst = 1'b1;
        #1 chk("rst_ready", s_ready, 0);
        step();
        rst = 1'b0;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_cnt", counts, 0);
        m_ready = 1'b1;
        s_valid = 4'b1111;
        step();
        chk("post_rst_port", m_tag[7:6], 0);

        enable = 1'b0;
        step();
        chk("en_off_ready", s_ready, 0);
        step();
        chk("en_off_valid", m_valid, 0);
        enable = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < P; i++) begin
                if ($urandom_range(3) == 0) set_port(i, TW'($urandom));
            end
            s_valid = P'($urandom);
            m_ready = ($urandom_range(3) != 0);
            enable = ($urandom_range(9) != 0);
            st_in_valid = ($urandom_range(2) == 0);
            st_in_tag = MT'($urandom);
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;
        s_valid = '0;
        st_in_valid = 1'b0;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
